pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Generic, parametrised pipeline stage register replacing the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one datapath bundle plus one control bundle per beat, with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer.
- Control bits of bubbles are forced to zero, so a flushed or empty stage can never assert register-file or memory write enables downstream.

Parameters:
- DATA_W, 96: width of datapath bundle (ALU result, memory data, operands, instruction).
- CTRL_W, 8: width of control bundle (write enables, mux selects).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational ready pass-through.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage accepts beat this cycle
- in_data  input  DATA_W  upstream datapath bundle
- in_ctrl  input  CTRL_W  upstream control bundle
- flush  input  1  discard all held and incoming beats
- out_valid  output  1  beat presented downstream
- out_ready  input  1  downstream accepts beat
- out_data  output  DATA_W  head datapath bundle
- out_ctrl  output  CTRL_W  head control bundle, zero when out_valid=0
- occupancy  output  2  number of held beats (0..2; max 1 when SKID=0)

Behaviour:
- Reset (rst=0, asynchronous): all valid bits 0, all data/ctrl storage 0, out_valid=0, out_ctrl=0, out_data=0, occupancy=0. in_ready=1 after reset deassertion (SKID=1); in_ready=out_ready-driven (SKID=0).
- Transfer in: in_valid & in_ready at posedge. Transfer out: out_valid & out_ready at posedge.
- Latency: one cycle in to out. Throughput: one beat/cycle when out_ready is held high.
- SKID=1 storage: main entry (head) and skid entry. State = occupancy: EMPTY(0), ONE(1), TWO(2).
- in_ready = (state != TWO). This is a registered signal with no combinational path from out_ready.
- EMPTY: accept -> ONE, beat loaded into main.
- ONE:
  - accept & drain -> ONE, main reloaded.
  - accept & no drain -> TWO, beat loaded into skid.
  - drain only -> EMPTY.
  - neither -> hold.
- TWO:
  - drain -> ONE, skid moves to main.
  - no drain -> hold. No accept is possible.
- SKID=0: single entry. in_ready = !out_valid | out_ready (combinational). Accept overwrites the entry; drain without accept -> empty.
- Order is preserved: the skid beat always leaves after the main beat.
- Flush (synchronous, highest priority): at posedge all valid bits clear and state -> EMPTY.
  - A simultaneous input handshake is dropped.
  - A simultaneous output handshake still counts as delivered downstream. The stage is not responsible for it.
  - Data storage is not cleared.
- Output gating: out_ctrl = valid ? stored ctrl : 0. out_data shows stored data regardless of valid.
- Stall: out_ready=0 holds out_data/out_ctrl stable until the handshake, including across fill to TWO.
- Reset mid-operation: held beats are lost immediately and asynchronously. No partial output glitch is required beyond the asynchronous clear.
- occupancy is updated at the same edge as the state and equals the count of valid entries.

Decomposition:
- Package pipe_pkg:
  - typedef occ_t (enum EMPTY=0, ONE=1, TWO=2).
  - localparam OCC_W=2.
  - Per-stage DATA_W/CTRL_W constants for IF/ID, ID/EX, EX/MEM, MEM/WB.
- Sub-module pipe_entry_reg: one valid+data+ctrl register with load/clear, asynchronous active-low reset. Instantiated once (SKID=0) or twice (SKID=1).

Test Plan:
- Reset then stream: rst low for 3 cycles; out_ready=1, in_valid=1 with in_data=0x1..0x8 -> out_data 0x1..0x8 on consecutive cycles, one-cycle latency, occupancy=1 throughout.
- Backpressure (SKID=1): send 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data holds 0xA. Raise out_ready -> 0xA then 0xB, and in_ready returns 1 one cycle after the first drain.
- Flush at TWO: hold 0xA/0xB, assert flush with in_valid=1 and in_data=0xC -> next cycle out_valid=0, out_ctrl=0, occupancy=0. 0xC is never emitted.
- Bubble gating: in_ctrl=0xFF with in_valid=0 -> out_ctrl=0x00. Then in_valid=1 with in_ctrl=0x05 -> out_ctrl=0x05 next cycle.
- Asynchronous reset mid-stall: occupancy=2, drop rst between clock edges -> out_valid and occupancy go 0 before the next posedge.
- SKID=0 build: out_ready=0 drives in_ready=0 in the same cycle. Simultaneous accept and drain replaces 0x3 with 0x4 in one cycle, occupancy stays 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and per-stage widths for elastic pipeline stages
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  localparam int IF_ID_DATA_W  = 64;
  localparam int IF_ID_CTRL_W  = 2;
  localparam int ID_EX_DATA_W  = 96;
  localparam int ID_EX_CTRL_W  = 8;
  localparam int EX_MEM_DATA_W = 96;
  localparam int EX_MEM_CTRL_W = 6;
  localparam int MEM_WB_DATA_W = 64;
  localparam int MEM_WB_CTRL_W = 4;

endpackage

// File: rtl/pipe_stage_elastic_entry.sv
// rtl/pipe_stage_elastic_entry.sv - one valid+data+ctrl holding register
// Clear only drops the valid bit; payload stays so out_data is stable on bubbles.
import pipe_pkg::*;

module pipe_entry_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      ctrl_q  <= ctrl_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - parametrised valid/ready pipeline stage with flush
// SKID=1 registers in_ready via a second entry; SKID=0 passes ready through.
import pipe_pkg::*;

module pipe_stage_elastic #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy
);

  logic              main_v;
  logic              main_load;
  logic              main_clr;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_ld_data;
  logic [CTRL_W-1:0] main_ld_ctrl;
  logic              accept;
  logic              drain;

  assign accept = in_valid & in_ready;
  assign drain  = main_v & out_ready;

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load),
    .clear_i (main_clr),
    .data_i  (main_ld_data),
    .ctrl_i  (main_ld_ctrl),
    .valid_o (main_v),
    .data_o  (main_data),
    .ctrl_o  (main_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_v;
      logic              skid_load;
      logic              skid_clr;
      logic [DATA_W-1:0] skid_data;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [OCC_W-1:0]  occ;
      occ_t              state;

      pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .data_i  (in_data),
        .ctrl_i  (in_ctrl),
        .valid_o (skid_v),
        .data_o  (skid_data),
        .ctrl_o  (skid_ctrl)
      );

      assign occ   = {1'b0, main_v} + {1'b0, skid_v};
      assign state = occ_t'(occ);

      // skid only ever holds a beat in TWO, so its valid bit alone gates ready
      assign in_ready  = ~skid_v;
      assign occupancy = occ;

      always_comb begin
        main_load    = 1'b0;
        main_clr     = flush;
        main_ld_data = in_data;
        main_ld_ctrl = in_ctrl;
        skid_load    = 1'b0;
        skid_clr     = flush;
        if (!flush) begin
          case (state)
            EMPTY: main_load = accept;
            ONE: begin
              if (accept && drain)  main_load = 1'b1;
              else if (accept)      skid_load = 1'b1;
              else if (drain)       main_clr  = 1'b1;
            end
            TWO: begin
              if (drain) begin
                main_load    = 1'b1;
                main_ld_data = skid_data;
                main_ld_ctrl = skid_ctrl;
                skid_clr     = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end else begin : g_noskid
      assign in_ready     = ~main_v | out_ready;
      assign occupancy    = {{(OCC_W-1){1'b0}}, main_v};
      assign main_ld_data = in_data;
      assign main_ld_ctrl = in_ctrl;
      assign main_load    = accept & ~flush;
      assign main_clr     = flush | (drain & ~accept);
    end
  endgenerate

  assign out_valid = main_v;
  assign out_data  = main_data;
  assign out_ctrl  = main_v ? main_ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - directed vector bench for pipe_stage_elastic
module tb_pipe_stage_elastic;

  localparam int DW = 96;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;

  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  logic          in_ready0, out_valid0;
  logic [DW-1:0] out_data0;
  logic [CW-1:0] out_ctrl0;
  logic [1:0]    occupancy0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ctrl(out_ctrl), .occupancy(occupancy)
  );

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_ctrl(out_ctrl0), .occupancy(occupancy0)
  );

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic [CW-1:0] ic;
    logic          fl;
    logic          ordy;
    logic          ov;
    logic [DW-1:0] od;
    logic [CW-1:0] oc;
    logic [1:0]    occ;
    logic          irdy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic iv, logic [DW-1:0] id, logic [CW-1:0] ic,
                              logic fl, logic ordy, logic ov, logic [DW-1:0] od,
                              logic [CW-1:0] oc, logic [1:0] occ, logic irdy);
    vec_t v;
    v.iv = iv; v.id = id; v.ic = ic; v.fl = fl; v.ordy = ordy;
    v.ov = ov; v.od = od; v.oc = oc; v.occ = occ; v.irdy = irdy;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                       input logic fl, input logic ordy);
    in_valid = iv; in_data = id; in_ctrl = ic; flush = fl; out_ready = ordy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // stream 0x1..0x8 with out_ready high
    for (int i = 1; i <= 8; i++)
      add(1, DW'(i), CW'(i), 0, 1, 1, DW'(i), CW'(i), 2'd1, 1);
    add(0, '0, '0, 0, 1, 0, DW'(8), 8'h00, 2'd0, 1);
    // backpressure into the skid entry
    add(1, DW'('hA), 8'h0A, 0, 0, 1, DW'('hA), 8'h0A, 2'd1, 1);
    add(1, DW'('hB), 8'h0B, 0, 0, 1, DW'('hA), 8'h0A, 2'd2, 0);
    add(1, DW'('hEE), 8'hEE, 0, 0, 1, DW'('hA), 8'h0A, 2'd2, 0);
    add(0, '0, '0, 0, 1, 1, DW'('hB), 8'h0B, 2'd1, 1);
    add(0, '0, '0, 0, 1, 0, DW'('hB), 8'h00, 2'd0, 1);
    // flush while full, incoming 0xC is dropped
    add(1, DW'('hA), 8'h0A, 0, 0, 1, DW'('hA), 8'h0A, 2'd1, 1);
    add(1, DW'('hB), 8'h0B, 0, 0, 1, DW'('hA), 8'h0A, 2'd2, 0);
    add(1, DW'('hC), 8'h0C, 1, 0, 0, DW'('hA), 8'h00, 2'd0, 1);
    add(0, '0, '0, 0, 1, 0, DW'('hA), 8'h00, 2'd0, 1);
    // bubble gating of control bits
    add(0, DW'('h55), 8'hFF, 0, 0, 0, DW'('hA), 8'h00, 2'd0, 1);
    add(1, DW'('h77), 8'h05, 0, 0, 1, DW'('h77), 8'h05, 2'd1, 1);
    // flush together with an output handshake
    add(0, '0, '0, 1, 1, 0, DW'('h77), 8'h00, 2'd0, 1);

    drive(0, '0, '0, 0, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_ctrl", 128'(out_ctrl), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    check("rst_occupancy", 128'(occupancy), 128'(0));
    rst = 1'b1;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].id, vecs[i].ic, vecs[i].fl, vecs[i].ordy);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), 128'(out_valid), 128'(vecs[i].ov));
      check($sformatf("v%0d_out_data", i), 128'(out_data), 128'(vecs[i].od));
      check($sformatf("v%0d_out_ctrl", i), 128'(out_ctrl), 128'(vecs[i].oc));
      check($sformatf("v%0d_occupancy", i), 128'(occupancy), 128'(vecs[i].occ));
      check($sformatf("v%0d_in_ready", i), 128'(in_ready), 128'(vecs[i].irdy));
    end

    // asynchronous reset while holding two beats
    @(negedge clk); drive(1, DW'('hA), 8'h0A, 0, 0);
    @(negedge clk); drive(1, DW'('hB), 8'h0B, 0, 0);
    @(posedge clk); #1;
    check("ar_occ_full", 128'(occupancy), 128'(2));
    drive(0, '0, '0, 0, 0);
    #1 rst = 1'b0;
    #1;
    check("ar_out_valid", 128'(out_valid), 128'(0));
    check("ar_occupancy", 128'(occupancy), 128'(0));
    check("ar_out_ctrl", 128'(out_ctrl), 128'(0));
    check("ar_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk); rst = 1'b1;

    // single-entry build: combinational ready and in-place replace
    @(negedge clk); drive(1, DW'('h3), 8'h03, 0, 0);
    @(posedge clk); #1;
    check("s0_occ_one", 128'(occupancy0), 128'(1));
    check("s0_data_3", 128'(out_data0), 128'(3));
    check("s0_in_ready_low", 128'(in_ready0), 128'(0));
    drive(1, DW'('h4), 8'h04, 0, 1);
    #1;
    check("s0_in_ready_comb", 128'(in_ready0), 128'(1));
    @(posedge clk); #1;
    check("s0_data_4", 128'(out_data0), 128'(4));
    check("s0_ctrl_4", 128'(out_ctrl0), 128'(4));
    check("s0_occ_stay", 128'(occupancy0), 128'(1));
    drive(0, '0, '0, 0, 0);
    #1;
    check("s0_in_ready_drop", 128'(in_ready0), 128'(0));
    @(negedge clk); drive(0, '0, '0, 0, 1);
    @(posedge clk); #1;
    check("s0_empty_valid", 128'(out_valid0), 128'(0));
    check("s0_empty_occ", 128'(occupancy0), 128'(0));
    check("s0_empty_ctrl", 128'(out_ctrl0), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
